clk_div_sequencer: RTL and testbench
====================================

// Module: clk_div_sequencer
// PURPOSE
//   Run-time controller for the system's divided sample clock (ADC/SPI timing).
//   Generates a divided clock from clock_in with a programmable divisor and
//   start/stop sequencing. A valid/ready port accepts new divisors, which
//   apply only on a period boundary, so clock_out never produces a runt
//   pulse. Sits between the config register file and the acquisition
//   front-end.
// PARAMETERS
//   CNT_W        28  width of divisor and period counter
//   DEFAULT_DIV  4   divisor loaded at reset
//   MIN_DIV      2   smallest legal divisor; smaller requests are rejected
// PORTS
//   clock_in     in   1      system clock
//   rstn         in   1      synchronous reset, active-low
//   start        in   1      level/pulse; begin (or resume) clock generation
//   stop         in   1      request stop at end of current period
//   cfg_div      in   CNT_W  requested divisor
//   cfg_valid    in   1      cfg_div valid
//   cfg_ready    out  1      controller can accept cfg_div
//   cfg_err      out  1      1-cycle pulse: accepted request had cfg_div<MIN_DIV
//   cur_div      out  CNT_W  divisor currently in effect
//   clock_out    out  1      divided clock (registered)
//   tick         out  1      1-cycle pulse coincident with each clock_out rise
//   busy         out  1      state != IDLE
// BEHAVIOUR
// - Reset (rstn=0 at edge): state=IDLE, counter=0, clock_out=0, tick=0,
//   cfg_err=0, cur_div=DEFAULT_DIV, pending cleared, cfg_ready=1.
// - States: IDLE, RUN, DRAIN. busy=1 in RUN and DRAIN.
// - IDLE: start -> RUN. At that edge: counter=0, clock_out=1, tick=1. stop is ignored.
// - RUN/DRAIN, every edge: counter <= (counter==cur_div-1) ? 0 : counter+1.
//   clock_out <= (new counter < cur_div/2), floor division. tick <= (new counter==0).
//   Result: high for floor(D/2) cycles, low for ceil(D/2); period is exactly D.
// - RUN: stop -> DRAIN. start is ignored. start and stop together -> DRAIN.
// - DRAIN: at the edge where counter==cur_div-1: -> IDLE, counter=0,
//   clock_out=0, tick=0. start before that edge -> RUN with no phase change.
// - Config handshake: transfer when cfg_valid && cfg_ready.
//   - cfg_div<MIN_DIV: cfg_err=1 next cycle, nothing stored.
//   - IDLE: cur_div<=cfg_div next cycle; cfg_ready stays 1.
//   - RUN/DRAIN: value held pending and cfg_ready=0 until applied. It is applied
//     at the wrap edge (counter==cur_div-1 -> 0). The new period starts with the
//     new divisor, so the first high phase is floor(new/2).
//   - Wrap edge that also ends DRAIN: the pending value is applied; state -> IDLE.
//   - start in IDLE in the same cycle as a transfer: RUN begins with the new divisor.
// - Counter arithmetic is CNT_W bits. cur_div>=MIN_DIV>=2 is guaranteed, so
//   cur_div-1 never underflows.
// - Reset mid-period: immediate, with no drain; clock_out drops to 0 at that edge.
// CONFIGURATION
// - CLKDIV_BURST_EN defined: adds input burst_len[15:0], sampled when RUN is
//   entered from IDLE. If burst_len!=0, the block enters DRAIN on its own after
//   burst_len ticks, so exactly burst_len full periods are produced, then IDLE.
//   burst_len=0 runs until stop.
// - Not defined: no burst_len port and no burst counter. RUN continues until stop.
// TESTING
// 1 Reset, start pulse, DEFAULT_DIV=4 -> clock_out 1,1,0,0 repeating; tick every 4th cycle.
// 2 IDLE, cfg_div=5 accepted, start -> high 2 cycles, low 3; cur_div=5.
// 3 RUN at D=4, cfg_div=6 mid-period -> cfg_ready=0 until wrap; next period is
//   3 high, 3 low; cfg_ready returns to 1.
// 4 cfg_div=1 -> cfg_err pulse, cur_div unchanged, cfg_ready stays 1.
// 5 stop at counter=1, D=4 -> 2 more cycles, IDLE, clock_out=0; start during
//   DRAIN keeps RUN with no glitch.
// 6 rstn low while clock_out=1 -> next edge clock_out=0, cur_div=4, busy=0;
//   with CLKDIV_BURST_EN, burst_len=3 -> exactly 3 ticks, then busy=0.

Source files
------------

// File: rtl/clk_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_sequencer
// Description : Programmable divided-clock generator with start/stop/drain
//               sequencing and a glitch-free divisor update handshake.
//               Optional burst mode is enabled by defining CLKDIV_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_sequencer #(
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 4,
  parameter int MIN_DIV     = 2
) (
  input  logic             clock_in,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_valid,
`ifdef CLKDIV_BURST_EN
  input  logic [15:0]      burst_len,
`endif
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             clock_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_MIN_DIV     = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  state_t           r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [CNT_W-1:0] r_cur_div,  w_cur_div_nxt;
  logic [CNT_W-1:0] r_pend_div, w_pend_div_nxt;
  logic             r_pending,  w_pending_nxt;
  logic             r_clk_out,  w_clk_out_nxt;
  logic             r_tick,     w_tick_nxt;
  logic             r_cfg_err,  w_cfg_err_nxt;

  logic w_xfer;
  logic w_bad_div;
  logic w_wrap;
  logic w_burst_done;

  assign cfg_ready = ~r_pending;
  assign w_xfer    = cfg_valid & cfg_ready;
  assign w_bad_div = (cfg_div < C_MIN_DIV);
  assign w_wrap    = (r_cnt == (r_cur_div - C_ONE));

`ifdef CLKDIV_BURST_EN
  // Ticks emitted since RUN was entered from IDLE; a zero length means unbounded.
  logic [15:0] r_burst_len;
  logic [15:0] r_burst_cnt;

  assign w_burst_done = (r_burst_len != 16'd0) && (r_burst_cnt == r_burst_len);

  always_ff @(posedge clock_in) begin
    if (!rstn) begin
      r_burst_len <= 16'd0;
      r_burst_cnt <= 16'd0;
    end else if (r_state == S_IDLE && start) begin
      r_burst_len <= burst_len;
      r_burst_cnt <= 16'd1;
    end else if (r_state == S_RUN && w_wrap &&
                 r_burst_len != 16'd0 && r_burst_cnt != r_burst_len) begin
      r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end
`else
  assign w_burst_done = 1'b0;
`endif

  always_ff @(posedge clock_in) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cur_div_nxt  = r_cur_div;
    w_pend_div_nxt = r_pend_div;
    w_pending_nxt  = r_pending;
    w_clk_out_nxt  = r_clk_out;
    w_tick_nxt     = 1'b0;
    w_cfg_err_nxt  = w_xfer & w_bad_div;

    // While the clock is running a new divisor waits for the period boundary.
    if (w_xfer && !w_bad_div) begin
      if (r_state == S_IDLE) begin
        w_cur_div_nxt = cfg_div;
      end else begin
        w_pend_div_nxt = cfg_div;
        w_pending_nxt  = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_RUN;
          w_cnt_nxt     = '0;
          w_clk_out_nxt = 1'b1;
          w_tick_nxt    = 1'b1;
        end
      end
      S_RUN, S_DRAIN: begin
        if (w_wrap) begin
          w_cnt_nxt = '0;
          if (r_pending) begin
            w_cur_div_nxt = r_pend_div;
            w_pending_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
        w_clk_out_nxt = (w_cnt_nxt < (w_cur_div_nxt >> 1));
        w_tick_nxt    = w_wrap;

        if (r_state == S_RUN) begin
          if (stop || w_burst_done) begin
            w_state_nxt = S_DRAIN;
          end
        end else if (w_wrap) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_clk_out_nxt = 1'b0;
          w_tick_nxt    = 1'b0;
        end else if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_cur_div  <= C_DEFAULT_DIV;
      r_pend_div <= '0;
      r_pending  <= 1'b0;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_cur_div  <= w_cur_div_nxt;
      r_pend_div <= w_pend_div_nxt;
      r_pending  <= w_pending_nxt;
      r_clk_out  <= w_clk_out_nxt;
      r_tick     <= w_tick_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
    end
  end

  assign cur_div   = r_cur_div;
  assign clock_out = r_clk_out;
  assign tick      = r_tick;
  assign cfg_err   = r_cfg_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_sequencer
// Description : Directed vector bench for clk_div_sequencer (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_sequencer;
  localparam int CNT_W = 28;
  localparam int NVEC  = 34;

  logic             clock_in  = 1'b0;
  logic             rstn      = 1'b0;
  logic             start     = 1'b0;
  logic             stop      = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div   = '0;
  logic             cfg_ready, cfg_err, clock_out, tick, busy;
  logic [CNT_W-1:0] cur_div;
`ifdef CLKDIV_BURST_EN
  logic [15:0]      burst_len = 16'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock_in = ~clock_in;

  clk_div_sequencer #(
    .CNT_W(CNT_W), .DEFAULT_DIV(4), .MIN_DIV(2)
  ) u_dut (
    .clock_in (clock_in),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .cfg_div  (cfg_div),
    .cfg_valid(cfg_valid),
`ifdef CLKDIV_BURST_EN
    .burst_len(burst_len),
`endif
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .cur_div  (cur_div),
    .clock_out(clock_out),
    .tick     (tick),
    .busy     (busy)
  );

  typedef struct {
    logic             rstn, start, stop, valid;
    logic [CNT_W-1:0] div;
    logic             e_clk, e_tick, e_busy, e_rdy, e_err;
    logic [CNT_W-1:0] e_cur;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic s, input logic p,
                              input logic v, input int d,
                              input logic ec, input logic et, input logic eb,
                              input logic er, input logic ee, input int ecur);
    vec_t t;
    t.rstn = r; t.start = s; t.stop = p; t.valid = v; t.div = CNT_W'(d);
    t.e_clk = ec; t.e_tick = et; t.e_busy = eb; t.e_rdy = er; t.e_err = ee;
    t.e_cur = CNT_W'(ecur);
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ec, input logic et,
                            input logic eb, input logic er, input logic ee,
                            input int ecur);
    chk({tag, " clock_out"}, int'(clock_out), int'(ec));
    chk({tag, " tick"},      int'(tick),      int'(et));
    chk({tag, " busy"},      int'(busy),      int'(eb));
    chk({tag, " cfg_ready"}, int'(cfg_ready), int'(er));
    chk({tag, " cfg_err"},   int'(cfg_err),   int'(ee));
    chk({tag, " cur_div"},   int'(cur_div),   ecur);
  endtask

  // Apply inputs for one edge and sample 1ns after it.
  task automatic step(input logic r, input logic s, input logic p,
                      input logic v, input int d);
    rstn = r; start = s; stop = p; cfg_valid = v; cfg_div = CNT_W'(d);
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    // reset, start at D=4, stop at counter=1
    vecs[0]  = mk(0,0,0,0,0, 0,0,0,1,0,4);
    vecs[1]  = mk(1,0,0,0,0, 0,0,0,1,0,4);
    vecs[2]  = mk(1,1,0,0,0, 1,1,1,1,0,4);
    vecs[3]  = mk(1,0,0,0,0, 1,0,1,1,0,4);
    vecs[4]  = mk(1,0,0,0,0, 0,0,1,1,0,4);
    vecs[5]  = mk(1,0,0,0,0, 0,0,1,1,0,4);
    vecs[6]  = mk(1,0,0,0,0, 1,1,1,1,0,4);
    vecs[7]  = mk(1,0,0,0,0, 1,0,1,1,0,4);
    vecs[8]  = mk(1,0,1,0,0, 0,0,1,1,0,4);
    vecs[9]  = mk(1,0,0,0,0, 0,0,1,1,0,4);
    vecs[10] = mk(1,0,0,0,0, 0,0,0,1,0,4);
    // divisor 5 loaded in IDLE: high 2, low 3
    vecs[11] = mk(1,0,0,1,5, 0,0,0,1,0,5);
    vecs[12] = mk(1,1,0,0,0, 1,1,1,1,0,5);
    vecs[13] = mk(1,0,0,0,0, 1,0,1,1,0,5);
    vecs[14] = mk(1,0,0,0,0, 0,0,1,1,0,5);
    vecs[15] = mk(1,0,0,0,0, 0,0,1,1,0,5);
    vecs[16] = mk(1,0,0,0,0, 0,0,1,1,0,5);
    vecs[17] = mk(1,0,0,0,0, 1,1,1,1,0,5);
    vecs[18] = mk(1,0,0,0,0, 1,0,1,1,0,5);
    vecs[19] = mk(1,0,1,0,0, 0,0,1,1,0,5);
    vecs[20] = mk(1,0,0,0,0, 0,0,1,1,0,5);
    vecs[21] = mk(1,0,0,0,0, 0,0,1,1,0,5);
    vecs[22] = mk(1,0,0,0,0, 0,0,0,1,0,5);
    // illegal divisor rejected
    vecs[23] = mk(1,0,0,1,1, 0,0,0,1,1,5);
    vecs[24] = mk(1,0,0,0,0, 0,0,0,1,0,5);
    // start together with transfer: runs at D=3; start+stop -> drain
    vecs[25] = mk(1,1,0,1,3, 1,1,1,1,0,3);
    vecs[26] = mk(1,0,0,0,0, 0,0,1,1,0,3);
    vecs[27] = mk(1,0,0,0,0, 0,0,1,1,0,3);
    vecs[28] = mk(1,0,0,0,0, 1,1,1,1,0,3);
    vecs[29] = mk(1,1,1,0,0, 0,0,1,1,0,3);
    vecs[30] = mk(1,0,0,0,0, 0,0,1,1,0,3);
    vecs[31] = mk(1,0,0,0,0, 0,0,0,1,0,3);
    vecs[32] = mk(1,0,0,1,4, 0,0,0,1,0,4);
    vecs[33] = mk(1,0,0,0,0, 0,0,0,1,0,4);

    @(negedge clock_in);
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rstn, vecs[i].start, vecs[i].stop, vecs[i].valid, int'(vecs[i].div));
      expect_out($sformatf("vec%0d", i), vecs[i].e_clk, vecs[i].e_tick,
                 vecs[i].e_busy, vecs[i].e_rdy, vecs[i].e_err, int'(vecs[i].e_cur));
    end

    // divisor change 4 -> 6 mid-period waits for the wrap
    begin
      logic [5:0] pat_clk;
      logic [5:0] pat_tick;
      pat_clk  = 6'b110001;
      pat_tick = 6'b000001;
      step(1,1,0,0,0); expect_out("upd start",   1,1,1,1,0,4);
      step(1,0,0,0,0); expect_out("upd c1",      1,0,1,1,0,4);
      step(1,0,0,1,6); expect_out("upd pend",    0,0,1,0,0,4);
      step(1,0,0,0,0); expect_out("upd hold",    0,0,1,0,0,4);
      step(1,0,0,0,0); expect_out("upd wrap",    1,1,1,1,0,6);
      for (int k = 0; k < 6; k++) begin
        step(1,0,0,0,0);
        expect_out($sformatf("upd d6 c%0d", k), pat_clk[5-k], pat_tick[5-k], 1, 1, 0, 6);
      end
      step(1,0,0,1,1); expect_out("run bad div", 1,0,1,1,1,6);
      step(1,0,0,0,0); expect_out("run err end", 1,0,1,1,0,6);
    end

    // start during drain resumes with no phase change
    step(0,0,0,0,0); expect_out("rst a",      0,0,0,1,0,4);
    step(1,1,0,0,0); expect_out("res start",  1,1,1,1,0,4);
    step(1,0,0,0,0); expect_out("res c1",     1,0,1,1,0,4);
    step(1,0,1,0,0); expect_out("res drain",  0,0,1,1,0,4);
    step(1,1,0,0,0); expect_out("res resume", 0,0,1,1,0,4);
    step(1,0,0,0,0); expect_out("res wrap",   1,1,1,1,0,4);
    step(1,0,0,0,0); expect_out("res c1b",    1,0,1,1,0,4);

    // reset while clock_out high with a pending divisor
    step(0,0,0,0,0); expect_out("rst b",      0,0,0,1,0,4);
    step(1,0,0,1,7); expect_out("mr load7",   0,0,0,1,0,7);
    step(1,1,0,0,0); expect_out("mr start",   1,1,1,1,0,7);
    step(1,0,0,1,5); expect_out("mr pend",    1,0,1,0,0,7);
    step(0,0,0,0,0); expect_out("mr reset",   0,0,0,1,0,4);
    step(1,0,0,0,0); expect_out("mr idle",    0,0,0,1,0,4);

`ifdef CLKDIV_BURST_EN
    begin
      int nticks;
      nticks = 0;
      burst_len = 16'd3;
      step(1,1,0,0,0);
      nticks += int'(tick);
      burst_len = 16'd0;
      for (int k = 1; k <= 12; k++) begin
        step(1,0,0,0,0);
        nticks += int'(tick);
        if (k == 11) chk("burst busy before end", int'(busy), 1);
        if (k == 12) chk("burst busy at end", int'(busy), 0);
      end
      for (int k = 0; k < 8; k++) begin
        step(1,0,0,0,0);
        nticks += int'(tick);
      end
      chk("burst tick count", nticks, 3);
      chk("burst idle clock_out", int'(clock_out), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
